// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and
// default latencies. The decoder and hazard unit also import this package.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int unsigned MDU_MULT_CYCLES = 5;
  localparam int unsigned MDU_DIV_CYCLES  = 10;
  localparam int unsigned MDU_CNT_W       = 4;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic is_long_op(input logic [3:0] op);
    logic res;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: res = 1'b1;
      default:                            res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// Sequencing for the multiply/divide unit: IDLE/BUSY FSM with a down-counter.
// busy is a flop; commit pulses during the last busy cycle so HI/LO are
// written on the same edge that returns the FSM to IDLE.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_launch,
  input  logic i_is_div,
  output logic busy,
  output logic commit
);

  localparam logic [MDU_CNT_W-1:0] LP_MULT_CNT = MDU_CNT_W'(MULT_CYCLES);
  localparam logic [MDU_CNT_W-1:0] LP_DIV_CNT  = MDU_CNT_W'(DIV_CYCLES);

  mdu_state_e             r_state;
  mdu_state_e             w_state_nxt;
  logic [MDU_CNT_W-1:0]   r_cnt;
  logic [MDU_CNT_W-1:0]   w_cnt_nxt;
  logic                   r_busy;
  logic                   w_busy_nxt;
  logic                   w_commit;

  // State, counter and busy flops; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next-state, counter reload/decrement and commit decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_launch) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = i_is_div ? LP_DIV_CNT : LP_MULT_CNT;
          w_busy_nxt  = 1'b1;
        end else begin
          w_busy_nxt  = 1'b0;
        end
      end
      ST_BUSY: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          w_busy_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign busy   = r_busy;
  assign commit = w_commit;

endmodule

// File: rtl/mul_div_unit.sv
// Multiply/divide unit: computes the result at launch into pending registers,
// then commits them to HI/LO after a fixed latency. rd reads the architectural
// HI/LO only, never the pending values.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  op,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] rd
);

  mdu_op_e     w_op;
  logic        w_accept;
  logic        w_launch;
  logic        w_is_div;
  logic        w_commit;
  logic [63:0] w_a64;
  logic [63:0] w_b64;
  logic [63:0] w_prod;
  logic        w_div_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_safe;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_pend_hi_nxt;
  logic [31:0] w_pend_lo_nxt;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  assign w_op     = mdu_op_e'(op);
  assign w_accept = start & ~busy;
  assign w_launch = w_accept & is_long_op(op);
  assign w_is_div = (w_op == OP_DIV) || (w_op == OP_DIVU);

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then
  // the correct signed or unsigned result.
  assign w_a64  = (w_op == OP_MULT) ? {{32{a[31]}}, a} : {32'd0, a};
  assign w_b64  = (w_op == OP_MULT) ? {{32{b[31]}}, b} : {32'd0, b};
  assign w_prod = w_a64 * w_b64;

  // Signed division on magnitudes; this also covers 0x80000000 / -1 without
  // relying on signed-overflow behaviour.
  assign w_div_signed = (w_op == OP_DIV);
  assign w_a_neg  = w_div_signed & a[31];
  assign w_b_neg  = w_div_signed & b[31];
  assign w_a_mag  = w_a_neg ? (32'd0 - a) : a;
  assign w_b_mag  = w_b_neg ? (32'd0 - b) : b;
  assign w_b_safe = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
  assign w_q_mag  = w_a_mag / w_b_safe;
  assign w_r_mag  = w_a_mag % w_b_safe;
  assign w_quo    = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_rem    = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

  // Select the value to park in the pending registers at launch. A zero
  // divisor parks the current HI/LO so the later commit changes nothing.
  always_comb begin
    w_pend_hi_nxt = r_pend_hi;
    w_pend_lo_nxt = r_pend_lo;
    case (w_op)
      OP_MULT, OP_MULTU: begin
        w_pend_hi_nxt = w_prod[63:32];
        w_pend_lo_nxt = w_prod[31:0];
      end
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) begin
          w_pend_hi_nxt = r_hi;
          w_pend_lo_nxt = r_lo;
        end else begin
          w_pend_hi_nxt = w_rem;
          w_pend_lo_nxt = w_quo;
        end
      end
      default: begin
        w_pend_hi_nxt = r_pend_hi;
        w_pend_lo_nxt = r_pend_lo;
      end
    endcase
  end

  // Pending result registers, loaded only when a long op is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
    end else if (w_launch) begin
      r_pend_hi <= w_pend_hi_nxt;
      r_pend_lo <= w_pend_lo_nxt;
    end else begin
      r_pend_hi <= r_pend_hi;
      r_pend_lo <= r_pend_lo;
    end
  end

  // Architectural HI/LO: written by commit or by an accepted MTHI/MTLO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_commit) begin
      r_hi <= r_pend_hi;
      r_lo <= r_pend_lo;
    end else if (w_accept && (w_op == OP_MTHI)) begin
      r_hi <= a;
    end else if (w_accept && (w_op == OP_MTLO)) begin
      r_lo <= a;
    end else begin
      r_hi <= r_hi;
      r_lo <= r_lo;
    end
  end

  // Read port toward writeback: HI or LO for the move-from ops, else zero.
  always_comb begin
    rd = 32'd0;
    case (w_op)
      OP_MFHI: rd = r_hi;
      OP_MFLO: rd = r_lo;
      default: rd = 32'd0;
    endcase
  end

  mdu_ctrl #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_ctrl (
    .clk     (clk),
    .reset_n (reset_n),
    .i_launch(w_launch),
    .i_is_div(w_is_div),
    .busy    (busy),
    .commit  (w_commit)
  );

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against an
// arithmetic reference model of HI/LO and the busy window.
module tb_mul_div_unit;

  localparam logic [3:0] OPC_NONE  = 4'd0;
  localparam logic [3:0] OPC_MULT  = 4'd1;
  localparam logic [3:0] OPC_MULTU = 4'd2;
  localparam logic [3:0] OPC_DIV   = 4'd3;
  localparam logic [3:0] OPC_DIVU  = 4'd4;
  localparam logic [3:0] OPC_MTHI  = 4'd5;
  localparam logic [3:0] OPC_MTLO  = 4'd6;
  localparam logic [3:0] OPC_MFHI  = 4'd7;
  localparam logic [3:0] OPC_MFLO  = 4'd8;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  op;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] rd;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] m_phi = 32'd0;
  logic [31:0] m_plo = 32'd0;
  int          m_left = 0;
  logic        m_write = 1'b0;

  mul_div_unit dut (
    .clk    (clk),
    .reset_n(reset_n),
    .op     (op),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .rd     (rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] ref_mul(input bit sgn, input logic [31:0] x, input logic [31:0] y);
    longint      sx;
    longint      sy;
    longint      p;
    logic [63:0] ux;
    logic [63:0] uy;
    if (sgn) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      p  = sx * sy;
      return p;
    end
    ux = {32'd0, x};
    uy = {32'd0, y};
    return ux * uy;
  endfunction

  // Returns {remainder, quotient}.
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] x, input logic [31:0] y);
    longint      sx;
    longint      sy;
    logic [63:0] q;
    logic [63:0] r;
    if (sgn) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = sx / sy;
      r  = sx % sy;
      return {r[31:0], q[31:0]};
    end
    return {x % y, x / y};
  endfunction

  function automatic logic [31:0] exp_rd();
    if (op == OPC_MFHI) return m_hi;
    if (op == OPC_MFLO) return m_lo;
    return 32'd0;
  endfunction

  // Reference model: architectural view of the unit, one step per clock.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hi <= 32'd0; m_lo <= 32'd0; m_phi <= 32'd0; m_plo <= 32'd0;
      m_left <= 0; m_write <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1 && m_write) begin
        m_hi <= m_phi;
        m_lo <= m_plo;
      end
    end else if (start) begin
      case (op)
        OPC_MULT:  begin {m_phi, m_plo} <= ref_mul(1'b1, a, b); m_left <= MC; m_write <= 1'b1; end
        OPC_MULTU: begin {m_phi, m_plo} <= ref_mul(1'b0, a, b); m_left <= MC; m_write <= 1'b1; end
        OPC_DIV: begin
          m_left <= DC; m_write <= (b != 32'd0);
          if (b != 32'd0) {m_phi, m_plo} <= ref_div(1'b1, a, b);
        end
        OPC_DIVU: begin
          m_left <= DC; m_write <= (b != 32'd0);
          if (b != 32'd0) {m_phi, m_plo} <= ref_div(1'b0, a, b);
        end
        OPC_MTHI: m_hi <= a;
        OPC_MTLO: m_lo <= a;
        default: ;
      endcase
    end
  end

  // Every-cycle compare of busy and rd against the model.
  always @(negedge clk) begin
    chk("busy_vs_model", {63'd0, busy}, {63'd0, (m_left > 0)});
    chk("rd_vs_model", {32'd0, rd}, {32'd0, exp_rd()});
  end

  task automatic issue(input logic [3:0] o, input logic [31:0] aa, input logic [31:0] bb);
    @(negedge clk); #1;
    op = o; a = aa; b = bb; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0; op = OPC_NONE;
  endtask

  task automatic read_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
    op = OPC_MFHI; #1;
    chk({name, "_mfhi"}, {32'd0, rd}, {32'd0, eh});
    op = OPC_MFLO; #1;
    chk({name, "_mflo"}, {32'd0, rd}, {32'd0, el});
    op = OPC_NONE;
  endtask

  // Launch a long op, optionally pulse a second start in the 2nd busy cycle,
  // and count busy cycles (bounded).
  task automatic run_long(input string name, input logic [3:0] o, input logic [31:0] aa,
                          input logic [31:0] bb, input int exp_cycles, input bit inj_en,
                          input logic [3:0] inj_op, input logic [31:0] inj_a, input logic [31:0] inj_b);
    int n;
    n = 0;
    issue(o, aa, bb);
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (inj_en && n == 2) begin
        op = inj_op; a = inj_a; b = inj_b; start = 1'b1;
      end else begin
        op = OPC_NONE; start = 1'b0;
      end
      @(negedge clk); #1;
    end
    start = 1'b0; op = OPC_NONE;
    chk({name, "_busy_cycles"}, 64'(n), 64'(exp_cycles));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int n;
    reset_n = 1'b0; op = OPC_MFHI; start = 1'b0; a = 32'd0; b = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    read_hilo("reset", 32'd0, 32'd0);
    reset_n = 1'b1;

    run_long("mult_neg2x3", OPC_MULT, 32'hFFFF_FFFE, 32'd3, 5, 1'b0, OPC_NONE, 32'd0, 32'd0);
    read_hilo("mult_neg2x3", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    run_long("multu", OPC_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 1'b0, OPC_NONE, 32'd0, 32'd0);
    read_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

    run_long("div_neg7_2", OPC_DIV, 32'hFFFF_FFF9, 32'd2, 10, 1'b0, OPC_NONE, 32'd0, 32'd0);
    read_hilo("div_neg7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    run_long("divu_by0", OPC_DIVU, 32'd7, 32'd0, 10, 1'b0, OPC_NONE, 32'd0, 32'd0);
    read_hilo("divu_by0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    run_long("div_min_m1", OPC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, OPC_NONE, 32'd0, 32'd0);
    read_hilo("div_min_m1", 32'd0, 32'h8000_0000);

    issue(OPC_MTHI, 32'h1234_5678, 32'd0);
    chk("mthi_no_busy", {63'd0, busy}, 64'd0);
    read_hilo("mthi", 32'h1234_5678, 32'h8000_0000);

    run_long("mult_mtlo_ign", OPC_MULT, 32'd3, 32'd5, 5, 1'b1, OPC_MTLO, 32'hDEAD_BEEF, 32'd0);
    read_hilo("mult_mtlo_ign", 32'd0, 32'd15);

    run_long("mult_restart_ign", OPC_MULT, 32'd7, 32'd9, 5, 1'b1, OPC_MULT, 32'd100, 32'd100);
    read_hilo("mult_restart_ign", 32'd0, 32'd63);

    // Reset during the 4th busy cycle of a divide.
    issue(OPC_DIV, 32'd100, 32'd7);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (n == 4) break;
      @(negedge clk); #1;
    end
    chk("abort_reached_cycle4", 64'(n), 64'd4);
    reset_n = 1'b0; #1;
    chk("abort_busy_low", {63'd0, busy}, 64'd0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (15) @(negedge clk);
    #1;
    read_hilo("abort_no_commit", 32'd0, 32'd0);

    // Randomized traffic checked by the every-cycle compare.
    repeat (600) begin
      @(negedge clk); #1;
      op    = 4'($urandom_range(0, 8));
      start = ($urandom_range(0, 2) == 0);
      a     = pick();
      b     = ($urandom_range(0, 5) == 0) ? 32'd0 : pick();
    end
    @(negedge clk); #1;
    start = 1'b0; op = OPC_MFLO;
    repeat (12) @(negedge clk);
    #1;
    chk("final_idle", {63'd0, busy}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  single rising-edge clock.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port op  input  4  operation: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
REQ-006 SHALL have port start  input  1  one-cycle qualifier for op; MF ops need no start.
REQ-007 SHALL have port a  input  32  rs operand, already forwarded, from the register-file read stage.
REQ-008 SHALL have port b  input  32  rt operand, already forwarded.
REQ-009 SHALL have port busy  output  1  high while a mult/div is in flight.
REQ-010 SHALL have port rd  output  32  HI for MFHI, LO for MFLO, else 0; feeds the writeback mux toward the register file.

Function
REQ-011 SHALL implement FSM states IDLE and BUSY, plus a 4-bit down-counter cnt.
REQ-012 In IDLE, start with MULT/MULTU/DIV/DIVU SHALL latch the result into pending_hi/pending_lo, load cnt with MULT_CYCLES or DIV_CYCLES, and enter BUSY at the next edge.
REQ-013 MULT/MULTU SHALL form the 64-bit signed/unsigned product: pending_hi is bits 63:32, pending_lo is bits 31:0.
REQ-014 DIV/DIVU SHALL produce signed/unsigned results: pending_lo is the quotient, pending_hi is the remainder.
REQ-015 Signed division SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-016 Division with b=0 SHALL still run DIV_CYCLES busy cycles and SHALL leave HI/LO unchanged.
REQ-017 Signed division of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-018 In BUSY, cnt SHALL decrement every cycle.
REQ-019 When cnt==1, HI/LO SHALL be written from the pending registers and the FSM SHALL return to IDLE at the same edge.
REQ-020 busy SHALL be registered: high exactly MULT_CYCLES/DIV_CYCLES cycles, starting the cycle after start.
REQ-021 HI/LO SHALL be visible on rd in the first cycle busy is low.
REQ-022 MTHI/MTLO with start in IDLE SHALL write a to HI/LO at the next edge; the other register SHALL be unchanged.
REQ-023 Any start received while busy is high SHALL be ignored, with no state change; hazard logic upstream stalls such instructions.
REQ-024 start with op NONE/MFHI/MFLO SHALL have no effect.
REQ-025 rd SHALL be combinational from op and the HI/LO registers, with no bypass of pending values.
REQ-026 MFHI/MFLO while busy SHALL return the pre-operation HI/LO.

Reset
REQ-027 reset_n low SHALL asynchronously clear HI, LO, pending_hi, pending_lo and cnt to 0, force IDLE, and drive busy to 0.
REQ-028 Reset asserted mid-operation SHALL abort the operation, with no HI/LO commit after release.
REQ-029 The first start accepted after reset deassertion SHALL be the one sampled at the first rising edge with reset_n high.

Structure
REQ-030 The op encodings, FSM state encodings and default cycle constants SHALL live in shared package mdu_pkg, also used by the decoder and hazard unit.
REQ-031 The FSM and counter SHALL be one sub-module, mdu_ctrl, with outputs busy and commit; the datapath and HI/LO registers SHALL stay in mul_div_unit.

Verification
REQ-032 Bench SHALL check: reset, then MULT a=0xFFFFFFFE(-2), b=3 -> busy high 5 cycles; then MFHI=0xFFFFFFFF, MFLO=0xFFFFFFFA.
REQ-033 Bench SHALL check: MULTU a=0xFFFFFFFF, b=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
REQ-034 Bench SHALL check: DIV a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU a=7, b=0 -> busy 10 cycles, HI/LO unchanged.
REQ-035 Bench SHALL check: MTHI a=0x12345678, then MFHI next cycle -> 0x12345678, LO untouched. Then MTLO asserted during a MULT's busy -> ignored, and LO equals the product.
REQ-036 Bench SHALL check: start DIV, assert reset_n low at busy cycle 4 -> busy=0 immediately; after release, HI=LO=0 and no late commit.
REQ-037 Bench SHALL check: a second MULT start pulsed while busy -> ignored; busy falls exactly 5 cycles after the first start, holding the first product.
